// File: rtl/dual_fifo_serial_tx.sv
// Two-channel transmit concentrator: per-channel show-ahead FIFOs feed a
// round-robin arbiter and a tagged, LSB-first UART-style framer.

module dual_fifo_serial_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, do_pop, do_wr;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the write.
    assign do_wr  = wr_en && (!full || do_pop);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

module dual_fifo_serial_tx #(
    parameter int BUFF_SIZE    = 8,
    parameter int FIFO_DEPTH   = 32,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 wr_en_fifo_1,
    input  logic [BUFF_SIZE-1:0] data_in_fifo_1,
    input  logic                 wr_en_fifo_2,
    input  logic [BUFF_SIZE-1:0] data_in_fifo_2,
    output logic                 tx
);
    localparam int NUM_CH = 2;
    localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW     = $clog2(BUFF_SIZE + 1);

    typedef enum logic [2:0] {IDLE, START, TAG, DATA, STOP} state_t;

    logic [NUM_CH-1:0]                wr_en, pop, empty;
    logic [NUM_CH-1:0][BUFF_SIZE-1:0] wr_data, head;

    state_t               state, state_d;
    logic [CW-1:0]        baud_cnt, baud_d;
    logic [BW-1:0]        bit_cnt, bit_d;
    logic [BUFF_SIZE-1:0] shift_q, shift_d;
    logic                 tag_q, tag_d, last_q, last_d, tx_d, run;
    logic                 sel, baud_end;

    assign wr_en      = {wr_en_fifo_2, wr_en_fifo_1};
    assign wr_data[0] = data_in_fifo_1;
    assign wr_data[1] = data_in_fifo_2;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dual_fifo_serial_tx_fifo #(.W(BUFF_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[g]),
            .wr_data (wr_data[g]),
            .pop     (pop[g]),
            .head    (head[g]),
            .empty   (empty[g])
        );
    end

    // Both pending: alternate away from last; otherwise take whichever has data.
    assign sel      = (!empty[0] && !empty[1]) ? ~last_q : empty[0];
    assign baud_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift_q;
        tag_d   = tag_q;
        last_d  = last_q;
        pop     = '0;
        case (state)
            IDLE: begin
                if (run && !(&empty)) begin
                    pop[sel] = 1'b1;
                    shift_d  = head[sel];
                    tag_d    = sel;
                    last_d   = sel;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = TAG;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            TAG: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_cnt == BW'(BUFF_SIZE - 1)) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next state so it changes on the entering edge.
        case (state_d)
            START:   tx_d = 1'b0;
            TAG:     tx_d = tag_d;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tag_q    <= 1'b0;
            last_q   <= 1'b1;
            run      <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift_q  <= shift_d;
            tag_q    <= tag_d;
            last_q   <= last_d;
            run      <= run | start;
            tx       <= tx_d;
        end
    end
endmodule

// File: tb/tb_dual_fifo_serial_tx.sv
// Bench for dual_fifo_serial_tx: decodes the serial line into frames and
// compares them with a queue-based round-robin reference model.

module tb_dual_fifo_serial_tx;
    localparam int BW     = 8;
    localparam int DEPTH  = 32;
    localparam int CPB    = 4;
    localparam int PERIOD = (BW + 3) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          wr1 = 1'b0, wr2 = 1'b0;
    logic [BW-1:0] d1 = '0, d2 = '0;
    logic          tx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rst_cnt  = 0;

    // Frames as {stop, tag, data}; rx_t holds the cycle the start bit appeared.
    logic [9:0]    rx_q[$];
    int            rx_t[$];
    logic [BW-1:0] mq1[$], mq2[$];
    logic [9:0]    exp_q[$];
    bit            m_last;

    dual_fifo_serial_tx #(.BUFF_SIZE(BW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .wr_en_fifo_1   (wr1),
        .data_in_fifo_1 (d1),
        .wr_en_fifo_2   (wr2),
        .data_in_fifo_2 (d2),
        .tx             (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_cnt++;

    initial begin : mon
        int t0, rc;
        logic [10:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                rc = rst_cnt;
                b  = '0;
                @(negedge clk);
                b[0] = tx;
                for (int k = 1; k < 11; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
                if (rc == rst_cnt) begin
                    rx_q.push_back({b[10], b[1], b[9:2]});
                    rx_t.push_back(t0);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; wr1 = 1'b0; wr2 = 1'b0; d1 = '0; d2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete(); rx_t.delete();
        mq1.delete(); mq2.delete(); exp_q.delete();
        m_last = 1'b1;
    endtask

    task automatic write_ch(input int ch, input logic [BW-1:0] v);
        @(negedge clk);
        if (ch == 0) begin wr1 = 1'b1; d1 = v; end
        else         begin wr2 = 1'b1; d2 = v; end
        @(negedge clk);
        wr1 = 1'b0; wr2 = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Reference model: FIFO capacity limit, then round-robin drain order.
    task automatic model_wr(input int ch, input logic [BW-1:0] v);
        if (ch == 0 && mq1.size() < DEPTH) mq1.push_back(v);
        if (ch == 1 && mq2.size() < DEPTH) mq2.push_back(v);
    endtask

    task automatic build_expected();
        bit ch;
        exp_q.delete();
        while (mq1.size() > 0 || mq2.size() > 0) begin
            if (mq1.size() > 0 && mq2.size() > 0) ch = !m_last;
            else ch = (mq1.size() == 0);
            if (ch == 1'b0) exp_q.push_back({1'b1, 1'b0, mq1.pop_front()});
            else            exp_q.push_back({1'b1, 1'b1, mq2.pop_front()});
            m_last = ch;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
        rst_n = 1'b1;
        m_last = 1'b1;
        write_ch(0, 8'h00);
        write_ch(0, 8'h00);
        write_ch(1, 8'h3C);
        pulse_start();
        repeat (20) @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_tx got %b want 0", tx); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx got %b want 1", tx); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete(); rx_t.delete();
        pulse_start();
        repeat (150) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL post_reset_frames got %0d want 0", rx_q.size()); end
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle got %b want 1", tx); end
    endtask

    task automatic test_no_start();
        do_reset();
        write_ch(0, 8'h05);
        repeat (60) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL no_start_idle frames %0d tx %b want 0 frames tx 1", rx_q.size(), tx);
        end
        pulse_start();
        repeat (60) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 1) begin n_fail++; $display("FAIL no_start_count got %0d want 1", rx_q.size()); end
        n_checks++;
        if (rx_q.size() < 1 || rx_q[0] !== {1'b1, 1'b0, 8'h05}) begin
            n_fail++; $display("FAIL no_start_frame got %h want %h", (rx_q.size() > 0) ? rx_q[0] : 10'h3ff, {1'b1, 1'b0, 8'h05});
        end
    endtask

    task automatic test_ch2_latency();
        int wcyc;
        do_reset();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        wr2 = 1'b1; d2 = 8'hA2;
        @(posedge clk);
        #1 wcyc = cyc;
        @(negedge clk); wr2 = 1'b0;
        repeat (60) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 1) begin n_fail++; $display("FAIL ch2_count got %0d want 1", rx_q.size()); end
        n_checks++;
        if (rx_q.size() < 1 || rx_q[0] !== {1'b1, 1'b1, 8'hA2}) begin
            n_fail++; $display("FAIL ch2_frame got %h want %h", (rx_q.size() > 0) ? rx_q[0] : 10'h3ff, {1'b1, 1'b1, 8'hA2});
        end
        n_checks++;
        if (rx_t.size() < 1 || rx_t[0] != wcyc + 1) begin
            n_fail++; $display("FAIL ch2_latency got %0d want %0d", (rx_t.size() > 0) ? rx_t[0] : -1, wcyc + 1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 31; i++) begin
            wr1 = 1'b1; d1 = BW'(i);
            wr2 = 1'b1; d2 = BW'(2 * i);
            mq1.push_back(BW'(i));
            mq2.push_back(BW'(2 * i));
            @(negedge clk);
        end
        wr1 = 1'b0; wr2 = 1'b0;
        repeat (62 * PERIOD + 50) @(negedge clk);
        build_expected();
        n_checks++;
        if (rx_q.size() != 62) begin n_fail++; $display("FAIL stream_count got %0d want 62", rx_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL stream_frame[%0d] got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 10'h3ff, exp_q[i]);
            end
        end
        for (int i = 1; i < rx_t.size(); i++) begin
            n_checks++;
            if (rx_t[i] - rx_t[i-1] != PERIOD) begin
                n_fail++; $display("FAIL stream_period[%0d] got %0d want %0d", i, rx_t[i] - rx_t[i-1], PERIOD);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        @(negedge clk);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            wr1 = 1'b1; d1 = BW'(i);
            model_wr(0, BW'(i));
            @(negedge clk);
        end
        wr1 = 1'b0;
        pulse_start();
        repeat ((DEPTH + 1) * PERIOD + 100) @(negedge clk);
        build_expected();
        n_checks++;
        if (rx_q.size() != DEPTH) begin n_fail++; $display("FAIL overflow_count got %0d want %0d", rx_q.size(), DEPTH); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL overflow_frame[%0d] got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 10'h3ff, exp_q[i]);
            end
        end
    endtask

    task automatic test_simul_wr_pop();
        do_reset();
        @(negedge clk);
        for (int i = 1; i <= DEPTH; i++) begin
            wr1 = 1'b1; d1 = BW'(i);
            model_wr(0, BW'(i));
            @(negedge clk);
        end
        wr1 = 1'b0; start = 1'b1;
        @(negedge clk);
        // The first pop lands on this write; the following write meets a full FIFO.
        start = 1'b0; wr1 = 1'b1; d1 = 8'h77;
        @(negedge clk);
        d1 = 8'h88;
        @(negedge clk);
        wr1 = 1'b0;
        mq1.push_back(8'h77);
        repeat ((DEPTH + 2) * PERIOD + 100) @(negedge clk);
        build_expected();
        n_checks++;
        if (rx_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL simul_count got %0d want %0d", rx_q.size(), DEPTH + 1); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL simul_frame[%0d] got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 10'h3ff, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int n1, n2, c1, c2, e1, e2;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n1 = $urandom_range(0, 40);
            n2 = $urandom_range(1, 40);
            c1 = 0; c2 = 0;
            @(negedge clk);
            while (c1 < n1 || c2 < n2) begin
                wr1 = (c1 < n1) && ($urandom_range(0, 1) == 1);
                wr2 = (c2 < n2) && ($urandom_range(0, 1) == 1);
                d1 = BW'($urandom);
                d2 = BW'($urandom);
                if (wr1) begin model_wr(0, d1); c1++; end
                if (wr2) begin model_wr(1, d2); c2++; end
                @(negedge clk);
            end
            wr1 = 1'b0; wr2 = 1'b0;
            e1 = mq1.size(); e2 = mq2.size();
            pulse_start();
            repeat ((e1 + e2) * PERIOD + 100) @(negedge clk);
            build_expected();
            n_checks++;
            if (rx_q.size() != e1 + e2) begin
                n_fail++; $display("FAIL random%0d_count got %0d want %0d", r, rx_q.size(), e1 + e2);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL random%0d_frame[%0d] got %h want %h", r, i, (i < rx_q.size()) ? rx_q[i] : 10'h3ff, exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_start();
        test_ch2_latency();
        test_back_to_back();
        test_overflow();
        test_simul_wr_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
